// File: rtl/temp_bcd_frontend.sv
// Temperature front end: converts a signed 0.1-degree sample and its change
// from the previous sample into sign + 3-digit BCD magnitudes (00.0-99.9).
// The conversion is a 10-step sequential double-dabble run on both values at once.
module temp_bcd_frontend #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_valid,
    input  logic [W-1:0] sample,
    output logic         sample_ready,
    output logic [3:0]   temp_value_ones,
    output logic [3:0]   temp_value_tens,
    output logic [3:0]   temp_value_huns,
    output logic         temp_value_sign,
    output logic [3:0]   temp_delta_ones,
    output logic [3:0]   temp_delta_tens,
    output logic [3:0]   temp_delta_huns,
    output logic         temp_delta_sign,
    output logic         out_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   s_q, s_d;
    logic [W-1:0]   prev_q, prev_d;
    logic           have_prev_q, have_prev_d;
    logic [9:0]     vbin_q, vbin_d;
    logic [9:0]     dbin_q, dbin_d;
    logic [11:0]    vbcd_q, vbcd_d;
    logic [11:0]    dbcd_q, dbcd_d;
    logic           vsign_q, vsign_d;
    logic           dsign_q, dsign_d;
    logic [11:0]    vout_q, vout_d;
    logic [11:0]    dout_q, dout_d;
    logic           vout_sign_q, vout_sign_d;
    logic           dout_sign_q, dout_sign_d;

    // One extra bit so that -2^(W-1) and the full-range difference cannot overflow.
    logic [W:0]     s_ext, p_ext, d_ext, s_abs, d_abs;
    logic [11:0]    vstep, dstep;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
    function automatic logic [11:0] dabble_step(input logic [11:0] bcd, input logic in_bit);
        logic [11:0] adj;
        for (int i = 0; i < 3; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        return (adj << 1) | {11'd0, in_bit};
    endfunction

    // Clamp a non-negative magnitude to 999 (99.9 degrees); larger values saturate silently.
    function automatic logic [9:0] sat999(input logic [W:0] mag);
        return (mag > (W+1)'(999)) ? 10'd999 : mag[9:0];
    endfunction

    // Sign-extended sample, difference from the previous sample, and their magnitudes.
    always_comb begin
        s_ext = {s_q[W-1], s_q};
        p_ext = {prev_q[W-1], prev_q};
        d_ext = s_ext - p_ext;
        s_abs = s_ext[W] ? -s_ext : s_ext;
        d_abs = d_ext[W] ? -d_ext : d_ext;
        vstep = dabble_step(vbcd_q, vbin_q[9]);
        dstep = dabble_step(dbcd_q, dbin_q[9]);
    end

    // Next-state logic for the conversion sequence and the output load in the last shift.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a variable unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        vbin_d      = vbin_q;
        dbin_d      = dbin_q;
        vbcd_d      = vbcd_q;
        dbcd_d      = dbcd_q;
        vsign_d     = vsign_q;
        dsign_d     = dsign_q;
        vout_d      = vout_q;
        dout_d      = dout_q;
        vout_sign_d = vout_sign_q;
        dout_sign_d = dout_sign_q;

        unique case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    s_d     = sample;
                    state_d = PREP;
                end
            end
            PREP: begin
                vbin_d  = sat999(s_abs);
                vsign_d = s_ext[W];
                if (have_prev_q) begin
                    dbin_d  = sat999(d_abs);
                    dsign_d = d_ext[W];
                end else begin
                    dbin_d  = 10'd0;
                    dsign_d = 1'b0;
                end
                prev_d      = s_q;
                have_prev_d = 1'b1;
                vbcd_d      = 12'd0;
                dbcd_d      = 12'd0;
                cnt_d       = 4'd0;
                state_d     = SHIFT;
            end
            SHIFT: begin
                vbcd_d = vstep;
                dbcd_d = dstep;
                vbin_d = vbin_q << 1;
                dbin_d = dbin_q << 1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    // Last step: all digits and signs become visible together in DONE.
                    vout_d      = vstep;
                    dout_d      = dstep;
                    vout_sign_d = vsign_q;
                    dout_sign_d = dsign_q;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset aborts any conversion.
    always_ff @(posedge clk) begin
        // NOTE: all registers here are plain flops (no memory arrays), so every one is reset explicitly.
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            s_q         <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            vbin_q      <= 10'd0;
            dbin_q      <= 10'd0;
            vbcd_q      <= 12'd0;
            dbcd_q      <= 12'd0;
            vsign_q     <= 1'b0;
            dsign_q     <= 1'b0;
            vout_q      <= 12'd0;
            dout_q      <= 12'd0;
            vout_sign_q <= 1'b0;
            dout_sign_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            vbin_q      <= vbin_d;
            dbin_q      <= dbin_d;
            vbcd_q      <= vbcd_d;
            dbcd_q      <= dbcd_d;
            vsign_q     <= vsign_d;
            dsign_q     <= dsign_d;
            vout_q      <= vout_d;
            dout_q      <= dout_d;
            vout_sign_q <= vout_sign_d;
            dout_sign_q <= dout_sign_d;
        end
    end

    assign sample_ready    = (state_q == IDLE);
    assign out_valid       = (state_q == DONE);
    assign temp_value_huns = vout_q[11:8];
    assign temp_value_tens = vout_q[7:4];
    assign temp_value_ones = vout_q[3:0];
    assign temp_value_sign = vout_sign_q;
    assign temp_delta_huns = dout_q[11:8];
    assign temp_delta_tens = dout_q[7:4];
    assign temp_delta_ones = dout_q[3:0];
    assign temp_delta_sign = dout_sign_q;

endmodule

// File: tb/tb_temp_bcd_frontend.sv
// Bench for temp_bcd_frontend: directed spec cases, backpressure, reset abort,
// zero handling and random samples against an arithmetic reference model.
module tb_temp_bcd_frontend;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sample_valid = 1'b0;
    logic [W-1:0] sample = '0;
    logic         sample_ready;
    logic [3:0]   temp_value_ones, temp_value_tens, temp_value_huns;
    logic         temp_value_sign;
    logic [3:0]   temp_delta_ones, temp_delta_tens, temp_delta_huns;
    logic         temp_delta_sign;
    logic         out_valid;
    logic [25:0]  obs;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          m_prev = 0;
    bit          m_have = 0;
    logic [25:0] held_exp = '0;

    temp_bcd_frontend #(.W(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_valid    (sample_valid),
        .sample          (sample),
        .sample_ready    (sample_ready),
        .temp_value_ones (temp_value_ones),
        .temp_value_tens (temp_value_tens),
        .temp_value_huns (temp_value_huns),
        .temp_value_sign (temp_value_sign),
        .temp_delta_ones (temp_delta_ones),
        .temp_delta_tens (temp_delta_tens),
        .temp_delta_huns (temp_delta_huns),
        .temp_delta_sign (temp_delta_sign),
        .out_valid       (out_valid)
    );

    always #5 clk = ~clk;

    assign obs = {temp_value_sign, temp_value_huns, temp_value_tens, temp_value_ones,
                  temp_delta_sign, temp_delta_huns, temp_delta_tens, temp_delta_ones};

    // Expected outputs for an accepted sample, from decimal arithmetic on the sample values.
    task automatic model(input int s, output logic [25:0] e);
        int mag, d, dm;
        bit vs, ds;
        vs  = (s < 0);
        mag = vs ? -s : s;
        if (mag > 999) mag = 999;
        d  = s - m_prev;
        ds = (d < 0);
        dm = ds ? -d : d;
        if (dm > 999) dm = 999;
        if (!m_have) begin
            dm = 0;
            ds = 0;
        end
        m_prev = s;
        m_have = 1;
        e = {vs, 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10),
             ds, 4'(dm / 100), 4'((dm / 10) % 10), 4'(dm % 10)};
    endtask

    task automatic model_reset();
        m_prev   = 0;
        m_have   = 0;
        held_exp = '0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (sample_ready === 1'b1) begin
                ok = 1;
                return;
            end
            @(negedge clk);
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_ready: sample_ready stayed %b, required 1 within 40 cycles", sample_ready);
    endtask

    // One full transaction: accept, check busy window, pulse timing and output hold/update.
    task automatic txn(input int s);
        logic [25:0] e;
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        model(s, e);
        sample       = W'(s);
        sample_valid = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 13; k++) begin
            vectors++;
            if (sample_ready !== (k == 13)) begin
                miscompares++;
                $display("FAIL txn_ready s=%0d k=%0d: got %b required %b", s, k, sample_ready, (k == 13));
            end
            vectors++;
            if (out_valid !== (k == 12)) begin
                miscompares++;
                $display("FAIL txn_out_valid s=%0d k=%0d: got %b required %b", s, k, out_valid, (k == 12));
            end
            vectors++;
            if (obs !== ((k >= 12) ? e : held_exp)) begin
                miscompares++;
                $display("FAIL txn_outputs s=%0d k=%0d: got %h required %h", s, k, obs,
                         (k >= 12) ? e : held_exp);
            end
            if (k < 13) begin
                // Busy-time samples must be ignored.
                sample_valid = (k < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
                sample       = W'($urandom);
                @(negedge clk);
            end
        end
        held_exp = e;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== 26'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h/%b required 0/0", obs, out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (sample_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b required 1", sample_ready);
        end
        model_reset();
    endtask

    task automatic test_directed();
        int          svals[5];
        logic [25:0] cexp[5];
        svals = '{405, 470, -30, 2047, -2048};
        cexp  = '{{1'b0, 12'h405, 1'b0, 12'h000},
                  {1'b0, 12'h470, 1'b0, 12'h065},
                  {1'b1, 12'h030, 1'b1, 12'h500},
                  {1'b0, 12'h999, 1'b0, 12'h999},
                  {1'b1, 12'h999, 1'b1, 12'h999}};
        for (int i = 0; i < 5; i++) begin
            txn(svals[i]);
            vectors++;
            if (obs !== cexp[i]) begin
                miscompares++;
                $display("FAIL directed s=%0d: got %h required %h", svals[i], obs, cexp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          since, pulses, accepts;
        logic [25:0] e_cur, e_prev;
        since   = 13;
        pulses  = 0;
        accepts = 0;
        e_cur   = held_exp;
        e_prev  = held_exp;
        for (int c = 0; c < 60; c++) begin
            sample_valid = (c < 40);
            sample       = W'(100);
            vectors++;
            if (sample_ready !== (since >= 13)) begin
                miscompares++;
                $display("FAIL b2b_ready c=%0d: got %b required %b", c, sample_ready, (since >= 13));
            end
            vectors++;
            if (out_valid !== (since == 12)) begin
                miscompares++;
                $display("FAIL b2b_out_valid c=%0d: got %b required %b", c, out_valid, (since == 12));
            end
            vectors++;
            if (obs !== ((since >= 12) ? e_cur : e_prev)) begin
                miscompares++;
                $display("FAIL b2b_outputs c=%0d: got %h required %h", c, obs,
                         (since >= 12) ? e_cur : e_prev);
            end
            if (since == 12) pulses++;
            if (sample_valid && since >= 13) begin
                accepts++;
                e_prev = e_cur;
                model(100, e_cur);
                since = 0;
            end
            @(negedge clk);
            since++;
        end
        sample_valid = 1'b0;
        held_exp     = e_cur;
        vectors++;
        if (pulses != 4 || accepts != 4) begin
            miscompares++;
            $display("FAIL b2b_pulse_count: got %0d pulses required 4", pulses);
        end
    endtask

    task automatic test_reset_mid_shift();
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        sample       = W'($urandom);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        // k=1 PREP, k=2..7 SHIFT cnt 0..5
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        vectors++;
        if (obs !== 26'd0 || sample_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midshift_reset: got %h ready %b required 0 ready 1", obs, sample_ready);
        end
        for (int i = 0; i < 15; i++) begin
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midshift_no_pulse i=%0d: got %b required 0", i, out_valid);
            end
            @(negedge clk);
        end
        txn(123);
        vectors++;
        if (obs !== {1'b0, 12'h123, 1'b0, 12'h000}) begin
            miscompares++;
            $display("FAIL midshift_after: got %h required %h", obs, {1'b0, 12'h123, 1'b0, 12'h000});
        end
    endtask

    task automatic test_zero();
        txn(0);
        txn(0);
        vectors++;
        if (obs !== 26'd0) begin
            miscompares++;
            $display("FAIL zero: got %h required 0", obs);
        end
    endtask

    task automatic test_random();
        logic signed [11:0] rs;
        int s;
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                rs = 12'($urandom);
                s  = rs;
            end else begin
                s = int'($urandom_range(0, 1998)) - 999;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            txn(s);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_shift();
        test_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
